// File: rtl/instr_fetch_pkg.sv
// Shared ISA definitions for the fetch stage: word width, reset vector default,
// the payload carried through the fetch output register, and address helpers.
package instr_fetch_pkg;

    localparam int                XLEN             = 32;
    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0]   INSTR_BYTES      = 32'd4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    // Instruction addresses are word aligned; the low two bits are ignored.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Output register plus a one-entry skid buffer. A word pushed while the
// output is held by a stall parks in the skid entry and moves to the output
// on the next consumption, so no word is lost or duplicated.
module fetch_skid_buffer
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        push_i,
    input  fetch_word_t push_word_i,
    input  logic        id_stall_i,
    output logic        out_valid_o,
    output fetch_word_t out_word_o,
    output logic        skid_valid_o
);

    logic        out_valid_q, out_valid_d;
    fetch_word_t out_word_q, out_word_d;
    logic        skid_valid_q, skid_valid_d;
    fetch_word_t skid_word_q, skid_word_d;
    logic        out_load;

    // Next-state for the output slot and the skid slot.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        out_load     = !out_valid_q || !id_stall_i;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                // Older parked word goes first; a same-cycle push refills the skid.
                out_word_d   = skid_word_q;
                out_valid_d  = 1'b1;
                skid_valid_d = push_i;
                if (push_i) begin
                    skid_word_d = push_word_i;
                end
            end else if (push_i) begin
                out_word_d  = push_word_i;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push_i) begin
            skid_valid_d = 1'b1;
            skid_word_d  = push_word_i;
        end
    end

    // Valid bits and the visible output fields, cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_word_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_word_q   <= out_word_d;
        end
    end

    // Skid payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload is qualified by skid_valid_q, so it needs no reset.
        skid_word_q <= skid_word_d;
    end

    assign out_valid_o  = out_valid_q;
    assign out_word_o   = out_word_q;
    assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word request at a time to instruction
// memory, tracks the outstanding request (RUN/WAIT/DROP), squashes wrong-path
// words on redirect and hands fetched instructions to decode through a skid
// buffer so that full throughput survives decode stalls.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            id_stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [15:0]     if_imm16
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_raw;
    logic [XLEN-1:0] req_addr;
    logic            accept;
    fetch_word_t     accept_word;
    logic            skid_valid;
    fetch_word_t     out_word;

    // Request generation, word acceptance and next-state for FSM, pc and latched address.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        addr_d            = addr_q;
        req_raw           = 1'b0;
        req_addr          = pc_q;
        accept            = 1'b0;
        accept_word.instr = imem_rdata;
        accept_word.pc    = pc_q;

        unique case (state_q)
            ST_RUN: begin
                // Issue is blocked while the skid entry is occupied.
                req_raw  = !skid_valid;
                req_addr = pc_q;
                if (redirect) begin
                    pc_d = word_align(redirect_target);
                end else if (req_raw) begin
                    if (imem_ready) begin
                        accept = 1'b1;
                        pc_d   = pc_q + INSTR_BYTES;
                    end else begin
                        addr_d  = pc_q;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req_raw        = 1'b1;
                req_addr       = addr_q;
                accept_word.pc = addr_q;
                if (redirect) begin
                    pc_d    = word_align(redirect_target);
                    state_d = imem_ready ? ST_RUN : ST_DROP;
                end else if (imem_ready) begin
                    accept  = 1'b1;
                    pc_d    = addr_q + INSTR_BYTES;
                    state_d = ST_RUN;
                end
            end
            ST_DROP: begin
                // Wrong-path request still in flight: keep it stable, discard its data.
                req_raw  = 1'b1;
                req_addr = addr_q;
                if (redirect) begin
                    pc_d = word_align(redirect_target);
                end
                if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state, fetch pc and the address latched at issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    // A request presented during reset would be abandoned anyway, so mask it.
    assign imem_req  = req_raw && !reset;
    assign imem_addr = req_addr;

    fetch_skid_buffer u_skid (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect),
        .push_i       (accept),
        .push_word_i  (accept_word),
        .id_stall_i   (id_stall),
        .out_valid_o  (if_valid),
        .out_word_o   (out_word),
        .skid_valid_o (skid_valid)
    );

    assign if_instr    = out_word.instr;
    assign if_pc       = out_word.pc;
    assign if_pc_plus4 = out_word.pc + INSTR_BYTES;
    assign if_imm16    = out_word.instr[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed vector table, hand-written corner-case
// sequences, and a randomized run checked against a program-order model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [15:0] if_imm16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_stall        (id_stall),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_imm16        (if_imm16)
    );

    // Instruction memory contents: address-dependent pattern plus one fixed word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2008_FFFF;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic step(input logic rdy, input logic stall, input logic rd, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset           = 1'b0;
        imem_ready      = rdy;
        id_stall        = stall;
        redirect        = rd;
        redirect_target = tgt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            reset      = 1'b1;
            imem_ready = 1'b0;
            id_stall   = 1'b0;
            redirect   = 1'b0;
            @(negedge clk);
            check("rst_req", {31'd0, imem_req}, 32'd0);
        end
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
    endtask

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    // Random-phase model state
    logic [31:0] exp_pc;
    logic        hold;
    logic [31:0] held_pc, held_instr;
    logic        prev_pending;
    logic [31:0] prev_addr;
    int          idle;

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Streaming from reset, then a 3-cycle memory wait at address 8.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 32'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b1, 32'd4};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b0, 32'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b0, 32'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'd8,  1'b0, 32'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 32'd8};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd12};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rdy, vecs[i].stall, 1'b0, 32'd0);
            check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_instr", i), if_instr, mem_word(vecs[i].exp_pc));
            end
        end

        // Decode stall fills output and skid; release drains them in order.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("stall_req_first", {31'd0, imem_req}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("stall_req_blocked", {31'd0, imem_req}, 32'd0);
        check("stall_pc_held", if_pc, 32'd4);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("release_pc0", if_pc, 32'd4);
        check("release_req0", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("release_pc1", if_pc, 32'd8);
        check("release_instr1", if_instr, mem_word(32'd8));
        check("release_addr1", imem_addr, 32'd12);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("release_pc2", if_pc, 32'd12);

        // Redirect while waiting: wrong-path word is dropped, refetch at aligned target.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("drop_req", {31'd0, imem_req}, 32'd1);
        check("drop_addr", imem_addr, 32'd4);
        check("drop_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("after_drop_addr", imem_addr, 32'h0000_0100);
        check("after_drop_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("redir_valid", {31'd0, if_valid}, 32'd1);
        check("redir_pc", if_pc, 32'h0000_0100);

        // Redirect plus ready while stalled with skid full: both entries flushed.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("flush_valid", {31'd0, if_valid}, 32'd0);
        check("flush_addr", imem_addr, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("flush_pc", if_pc, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("flush_pc_next", if_pc, 32'h0000_0204);

        // Immediate field and pc+4 for a known instruction.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("imm_instr", if_instr, 32'h2008_FFFF);
        check("imm16", {16'd0, if_imm16}, 32'h0000_FFFF);
        check("imm_pc_plus4", if_pc_plus4, 32'h0000_0044);

        // pc arithmetic wraps at the top of the address space.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", if_pc_plus4, 32'h0000_0000);
        check("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Reset in the middle of an outstanding request abandons it.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("midreq_addr", imem_addr, 32'd8);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("post_reset_req", {31'd0, imem_req}, 32'd1);
        check("post_reset_addr", imem_addr, 32'd0);

        // Randomized run: consumed instructions must follow program order from
        // RESET_PC, restarting at each aligned redirect target.
        do_reset();
        exp_pc       = 32'd0;
        hold         = 1'b0;
        prev_pending = 1'b0;
        prev_addr    = '0;
        held_pc      = '0;
        held_instr   = '0;
        idle         = 0;
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 29) == 0, $urandom);
            if (prev_pending) begin
                check("rnd_req_stable", {31'd0, imem_req}, 32'd1);
                check("rnd_addr_stable", imem_addr, prev_addr);
            end
            if (hold) begin
                check("rnd_hold_valid", {31'd0, if_valid}, 32'd1);
                check("rnd_hold_pc", if_pc, held_pc);
                check("rnd_hold_instr", if_instr, held_instr);
            end
            hold         = 1'b0;
            prev_pending = imem_req && !imem_ready && !redirect;
            prev_addr    = imem_addr;
            idle++;
            if (redirect) begin
                exp_pc = {redirect_target[31:2], 2'b00};
                idle   = 0;
            end else if (if_valid) begin
                if (!id_stall) begin
                    check("rnd_pc", if_pc, exp_pc);
                    check("rnd_instr", if_instr, mem_word(exp_pc));
                    check("rnd_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
                    check("rnd_imm16", {16'd0, if_imm16}, {16'd0, mem_word(exp_pc) & 32'h0000_FFFF} & 32'h0000_FFFF);
                    exp_pc = exp_pc + 32'd4;
                    idle   = 0;
                end else begin
                    hold       = 1'b1;
                    held_pc    = if_pc;
                    held_instr = if_instr;
                end
            end
            if (idle > 200) begin
                checks++;
                errors++;
                $display("FAIL rnd_progress actual=%0d idle cycles expected=<=200", idle);
                idle = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
